// File: rtl/shift_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : shift_pkg                                                        |
// | Purpose : Shared definitions for the shift_arbiter block:                  |
// |           shift direction codes, output-register state encoding and the    |
// |           round-robin priority search used to pick a requester.            |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package shift_pkg;

   // Shift direction as presented on req_dir.
   localparam logic DIR_LEFT  = 1'b0;
   localparam logic DIR_RIGHT = 1'b1;

   // Widest arbiter the search function has to cover.
   localparam int unsigned c_max_req = 8;

   // Output result register: either empty or holding one result.
   typedef enum logic [0:0] {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } out_state_t;

   // Result of the round-robin search.
   typedef struct packed {
      logic       found;
      logic [2:0] idx;
   } rr_pick_t;

   // Return the first asserted valid bit, starting at ptr and walking upward
   // with wrap at nreq. Bits of valid at or above nreq are ignored. Because
   // ptr < nreq and the offset is < nreq, a single subtraction implements the
   // modulo wrap.
   function automatic rr_pick_t rr_pick(
      input logic [7:0]  valid,
      input logic [2:0]  ptr,
      input int unsigned nreq
   );
      rr_pick_t    r;
      int unsigned cand;
      r = '0;
      for (int unsigned k = 0; k < c_max_req; k++) begin
         cand = int'(ptr) + k;
         if (cand >= nreq) begin
            cand = cand - nreq;
         end
         if ((k < nreq) && !r.found && valid[cand[2:0]]) begin
            r.found = 1'b1;
            r.idx   = cand[2:0];
         end
      end
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/shift_arbiter_barrel_shifter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : Bidirectional_Barrel_Shifter                                     |
// | Purpose : 8-bit logical barrel shifter, left or right by 0..7 bits.        |
// |           Vacated bits are filled with zero.                               |
// | Ports   : data_in  [7:0] operand                                           |
// |           shamt    [2:0] shift amount                                      |
// |           dir            0 = left, 1 = right                               |
// |           data_out [7:0] shifted result                                    |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module Bidirectional_Barrel_Shifter
   import shift_pkg::*;
(
   input  logic [7:0] data_in,
   input  logic [2:0] shamt,
   input  logic       dir,
   output logic [7:0] data_out
);

   logic [7:0] w_pre;
   logic [7:0] w_s1;
   logic [7:0] w_s2;
   logic [7:0] w_s4;

   function automatic logic [7:0] bit_reverse(input logic [7:0] v);
      logic [7:0] r;
      r = '0;
      for (int b = 0; b < 8; b++) begin
         r[b] = v[7-b];
      end
      return r;
   endfunction

   // A right shift is done as reverse / shift-left / reverse, so only one
   // set of log-shifter stages is needed for both directions.
   always_comb begin
      w_pre    = (dir == DIR_RIGHT) ? bit_reverse(data_in) : data_in;
      w_s1     = shamt[0] ? {w_pre[6:0], 1'b0}  : w_pre;
      w_s2     = shamt[1] ? {w_s1[5:0],  2'b00} : w_s1;
      w_s4     = shamt[2] ? {w_s2[3:0],  4'h0}  : w_s2;
      data_out = (dir == DIR_RIGHT) ? bit_reverse(w_s4) : w_s4;
   end

endmodule
`default_nettype wire

// File: rtl/shift_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : shift_arbiter                                                    |
// | Purpose : Round-robin arbiter sharing one 8-bit barrel shifter among NREQ  |
// |           requesters. One request is granted per cycle; the shifted        |
// |           result is stored with the requester ID in a one-entry output     |
// |           register and held under backpressure.                            |
// | Ports   : clk, rst_n          clock, synchronous active-low reset          |
// |           req_valid/req_ready per-requester handshake (ready is one-hot)   |
// |           req_data  [8*NREQ]  operands                                     |
// |           req_shamt [3*NREQ]  shift amounts                                |
// |           req_dir   [NREQ]    directions (0 left, 1 right)                 |
// |           res_valid/res_ready result handshake                             |
// |           res_data  [8]       shifted result                               |
// |           res_id    [IDW]     index of the producing requester             |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module shift_arbiter
   import shift_pkg::*;
#(
   parameter  int unsigned NREQ = 2,
   localparam int          IDW  = $clog2(NREQ)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [8*NREQ-1:0] req_data,
   input  logic [3*NREQ-1:0] req_shamt,
   input  logic [NREQ-1:0]   req_dir,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [7:0]        res_data,
   output logic [IDW-1:0]    res_id
);

   out_state_t     r_state;
   out_state_t     w_state_next;
   logic [IDW-1:0] r_ptr;
   logic [7:0]     r_res_data;
   logic [IDW-1:0] r_res_id;

   rr_pick_t       w_pick;
   logic           w_idx_ok;
   logic [IDW-1:0] w_gidx;
   logic           w_can_issue;
   logic           w_accept;
   logic           w_drain;
   logic [NREQ-1:0] w_grant;
   logic [7:0]     w_opnd;
   logic [2:0]     w_shamt;
   logic           w_dir;
   logic [7:0]     w_shifted;

   // Priority search depends only on valid bits and the pointer, so
   // req_ready never depends on payload.
   assign w_pick   = rr_pick(8'(req_valid), 3'(r_ptr), NREQ);
   // The search never returns an index >= NREQ; the guard keeps the upper
   // index bits meaningful when IDW is narrower than the search width.
   assign w_idx_ok = ({1'b0, w_pick.idx} < 4'(NREQ));
   assign w_gidx   = w_pick.idx[IDW-1:0];

   // A new result may be issued if the register is empty or is being
   // drained this same cycle (back-to-back, no bubble).
   assign w_can_issue = (r_state == ST_EMPTY) | res_ready;
   assign w_accept    = rst_n & w_can_issue & w_pick.found & w_idx_ok;
   assign w_drain     = (r_state == ST_FULL) & res_ready;

   always_comb begin
      w_grant = '0;
      if (w_accept) begin
         w_grant[w_gidx] = 1'b1;
      end
   end

   assign req_ready = w_grant;

   // Payload mux for the granted requester.
   always_comb begin
      w_opnd  = '0;
      w_shamt = '0;
      w_dir   = DIR_LEFT;
      for (int i = 0; i < int'(NREQ); i++) begin
         if (w_gidx == IDW'(i)) begin
            w_opnd  = req_data[8*i +: 8];
            w_shamt = req_shamt[3*i +: 3];
            w_dir   = req_dir[i];
         end
      end
   end

   Bidirectional_Barrel_Shifter u_shifter (
      .data_in  (w_opnd),
      .shamt    (w_shamt),
      .dir      (w_dir),
      .data_out (w_shifted)
   );

   // Output-register FSM: next state.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_EMPTY: begin
            if (w_accept) begin
               w_state_next = ST_FULL;
            end
         end
         ST_FULL: begin
            if (w_drain && !w_accept) begin
               w_state_next = ST_EMPTY;
            end
         end
         default: begin
            w_state_next = ST_EMPTY;
         end
      endcase
   end

   // State, pointer and result register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= ST_EMPTY;
         r_ptr      <= '0;
         r_res_data <= '0;
         r_res_id   <= '0;
      end else begin
         r_state <= w_state_next;
         if (w_accept) begin
            r_res_data <= w_shifted;
            r_res_id   <= w_gidx;
            r_ptr      <= (w_gidx == IDW'(NREQ - 1)) ? '0 : (w_gidx + IDW'(1));
         end
      end
   end

   assign res_valid = (r_state == ST_FULL);
   assign res_data  = r_res_data;
   assign res_id    = r_res_id;

endmodule
`default_nettype wire

// File: doc/shift_arbiter.md
# shift_arbiter

Round-robin arbiter and sequencer that shares one 8-bit bidirectional logical barrel shifter among NREQ requesters. Each requester presents an operand, a 3-bit shift amount and a direction over a valid/ready handshake. The block grants one request per cycle and drives the shared shifter with the winning operands. The shifted result is captured in a one-entry output register, tagged with the requester ID, and held under backpressure until a downstream consumer accepts it.

## Interface
- NREQ, 2: number of requesters; legal range 2..8.
- IDW, $clog2(NREQ): width of the requester-ID tag; derived, never overridden.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester grant; one-hot or zero.
- req_data  in  8*NREQ  operand; requester i uses bits [8i+7:8i].
- req_shamt  in  3*NREQ  shift amount 0..7; requester i uses bits [3i+2:3i].
- req_dir  in  NREQ  direction: 0 = left, 1 = right.
- res_valid  out  1  result register holds a valid entry.
- res_ready  in  1  consumer accepts the result.
- res_data  out  8  shifted result.
- res_id  out  IDW  index of the requester that produced res_data.

## Operation
- Shift function:
  - Logical shift; vacated bits fill with 0.
  - shamt = 0 passes the operand through unchanged.
  - Result width is always 8 bits; bits shifted out are discarded.
- Output register FSM, two states:
  - EMPTY: res_valid = 0.
  - FULL: res_valid = 1.
- Definitions:
  - accept = |(req_valid & req_ready).
  - drain = res_valid & res_ready.
- FSM transitions:
  - EMPTY → FULL on accept.
  - FULL → EMPTY on drain without accept.
  - FULL → FULL on drain with accept: back-to-back, new result overwrites.
  - FULL → FULL with no drain: result held stable.
- can_issue = (state == EMPTY) | res_ready.
- Grant rules:
  - When can_issue = 0, req_ready = 0.
  - Otherwise the grant goes to the first requester with req_valid = 1, searching from the priority pointer ptr upward with modulo-NREQ wrap.
- Pointer update:
  - On accept by requester g, ptr ← (g+1) mod NREQ.
  - ptr is unchanged on cycles with no accept.
- On accept, the result register loads the shifter output for requester g, and res_id loads g.
- req_ready is combinational from req_valid, ptr and state/res_ready. It must not depend on req_data, req_shamt or req_dir.
- Requester rules:
  - Once req_valid is asserted, a requester holds its valid and payload stable until it sees req_ready.
  - The block does not check this; the bench asserts it.
- A requester that deasserts req_valid before its grant is simply skipped. No state is retained for it.
- Reset (rst_n = 0 at an edge):
  - State → EMPTY, ptr → 0, res_data → 0, res_id → 0.
  - Any held result is dropped, including one in mid-backpressure.
  - req_ready = 0 while rst_n = 0.

## Timing
- Latency: a request accepted at edge k gives res_valid = 1 with data from edge k. This is 1 cycle.
- Throughput: 1 result per cycle while res_ready stays high.
- Fairness: with all NREQ requesters continuously valid and res_ready = 1, grants rotate 0, 1, …, NREQ−1, 0, …
  - Maximum wait for a valid requester is NREQ−1 grants.
- Backpressure:
  - res_data and res_id stay stable while res_valid = 1 and res_ready = 0.
  - req_ready stays 0 for all requesters during this time.
- Combinational path is: ptr → priority search → mux of payload → shifter → result register. This is a single cycle.

## Structure
- Shared package shift_pkg holds:
  - DIR_LEFT = 1'b0 and DIR_RIGHT = 1'b1.
  - Output-FSM state encoding: ST_EMPTY, ST_FULL.
  - Function rr_pick(valid, ptr), returning the grant index plus a found flag.
- One sub-module: the existing 8-bit Bidirectional_Barrel_Shifter, instantiated exactly once with the granted operand, shamt and dir.
- Payload selection, grant and the result register live in shift_arbiter.

## Test plan
- Reset:
  - Stimulus: hold rst_n = 0 for 2 cycles with all req_valid = 1.
  - Required: req_ready = 0, res_valid = 0, res_data = 0x00, res_id = 0.
  - First grant after release goes to requester 0.
- Shift values, single requester 0:
  - 0xB5, shamt 3, dir 0 → res_data 0xA8, res_id 0, one cycle later.
  - 0xB5, shamt 3, dir 1 → 0x16.
  - shamt 0 → 0xB5.
  - 0xFF, shamt 7, dir 1 → 0x01.
- Round-robin, NREQ = 2, both continuously valid, res_ready = 1:
  - Requester 0 sends 0x01, shamt 1, left. Requester 1 sends 0x80, shamt 1, right.
  - Results alternate 0x02/id0 and 0x40/id1 on consecutive cycles.
- Backpressure:
  - res_ready = 0 for 4 cycles after the first result.
  - res_data and res_id stay frozen; req_ready = 0 throughout.
  - On res_ready = 1, the next request is granted in the same cycle, with no bubble.
- Reset mid-operation:
  - Assert rst_n = 0 while FULL and stalled.
  - The result is dropped and res_valid = 0 next cycle.
  - ptr returns to 0; after release, requester 0 wins even if requester 1 was last granted.
